// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Purpose : bundles the two handshakes of the instruction-fetch controller.
//           The memory side is a req/ack pair. The decode side is a
//           valid/ready pair.
// Signals :
//   fetch_req   - fetch request to instruction memory
//   fetch_addr  - word address; held stable while fetch_req=1
//   fetch_ack   - memory completes the request; fetch_data valid this cycle
//   fetch_data  - fetched instruction word
//   instr       - instruction to decode
//   instr_valid - instr is valid
//   instr_ready - decode accepts instr
// Modports:
//   master - the sequencer (drives fetch_req/addr, instr/valid)
//   slave  - memory + decode side (drives fetch_ack/data, instr_ready)
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             fetch_req;
    logic [WIDTH-1:0] fetch_addr;
    logic             fetch_ack;
    logic [WIDTH-1:0] fetch_data;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  fetch_data,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output fetch_data,
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Purpose : instruction-fetch controller. It owns the program counter, issues
//           word-addressed fetches to instruction memory, and hands fetched
//           words to decode. It also applies branch redirects and stops on
//           halt.
// Ports   :
//   clk               - clock, all state changes on posedge
//   reset             - asynchronous, active-high
//   io_bus            - pc_sequencer_if.master (fetch req/ack, instr valid/ready)
//   i_run             - permits new fetches
//   i_redirect_valid  - branch/jump taken
//   i_redirect_target - new PC
//   i_halt            - stop request
//   o_halted          - core halted (only reset leaves this state)
//   o_pc              - current PC (address of the next fetch)
//   o_fetch_err       - watchdog pulse (FETCH_TIMEOUT_EN builds only)
//   o_state           - current FSM state, for debug/checkers
// Build option:
//   FETCH_TIMEOUT_EN  - when defined, a request that waits TIMEOUT_CYCLES
//                       cycles without ack is abandoned. fetch_err pulses and
//                       the block halts. When undefined, REQ waits forever.
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR   = '0,
    parameter logic [WIDTH-1:0] PC_STEP        = WIDTH'(1),
    parameter int unsigned      TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.master    io_bus,
    input  logic              i_run,
    input  logic              i_redirect_valid,
    input  logic [WIDTH-1:0]  i_redirect_target,
    input  logic              i_halt,
    output logic              o_halted,
    output logic [WIDTH-1:0]  o_pc,
    output logic              o_fetch_err,
    output logic [1:0]        o_state
);

    // Handshakes:
    //  - Memory: fetch_req rises with fetch_addr, and both are held until the
    //    cycle fetch_ack=1. fetch_data is valid in that cycle. An ack seen
    //    outside REQ is ignored.
    //  - Decode: a transfer happens on a clock edge where instr_valid=1 and
    //    instr_ready=1. instr is held stable until then. A redirect in that
    //    same cycle squashes the word, so no transfer takes place.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             r_fetch_req;
    logic             w_fetch_req_nxt;
    logic [WIDTH-1:0] r_fetch_addr;
    logic [WIDTH-1:0] w_fetch_addr_nxt;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] w_instr_nxt;
    logic             r_instr_valid;
    logic             w_instr_valid_nxt;
    logic             r_halted;
    logic             w_halted_nxt;
    // r_flush: a redirect arrived while a request was in flight. The word
    // that comes back belongs to the old path and must be dropped.
    logic             r_flush;
    logic             w_flush_nxt;
    // r_halt_pend: a halt arrived mid-fetch. The fetch is finished first.
    logic             r_halt_pend;
    logic             w_halt_pend_nxt;
    logic             w_timeout;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_fetch_req_nxt   = r_fetch_req;
        w_fetch_addr_nxt  = r_fetch_addr;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_halted_nxt      = r_halted;
        w_flush_nxt       = r_flush;
        w_halt_pend_nxt   = r_halt_pend;

        case (r_state)
            S_IDLE: begin
                if (i_redirect_valid) begin
                    w_pc_nxt = i_redirect_target;
                end
                if (i_halt) begin
                    w_state_nxt  = S_HALT;
                    w_halted_nxt = 1'b1;
                end else if (i_run) begin
                    w_state_nxt      = S_REQ;
                    w_fetch_req_nxt  = 1'b1;
                    w_fetch_addr_nxt = i_redirect_valid ? i_redirect_target : r_pc;
                end
            end

            S_REQ: begin
                if (i_halt) begin
                    w_halt_pend_nxt = 1'b1;
                end
                if (io_bus.fetch_ack) begin
                    if (i_redirect_valid || r_flush) begin
                        // The returned word is on a dead path: drop it.
                        w_flush_nxt = 1'b0;
                        if (i_redirect_valid) begin
                            w_pc_nxt = i_redirect_target;
                        end
                        if (i_halt || r_halt_pend) begin
                            w_state_nxt     = S_HALT;
                            w_fetch_req_nxt = 1'b0;
                            w_halted_nxt    = 1'b1;
                        end else begin
                            // Re-issue right away at the redirected PC.
                            w_fetch_addr_nxt = i_redirect_valid ? i_redirect_target : r_pc;
                        end
                    end else begin
                        w_instr_nxt       = io_bus.fetch_data;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_nxt          = r_pc + PC_STEP;
                        w_fetch_req_nxt   = 1'b0;
                        w_state_nxt       = S_HOLD;
                    end
                end else begin
                    // The request stays unchanged. A redirect only retargets
                    // the PC and marks the in-flight word for discard.
                    if (i_redirect_valid) begin
                        w_pc_nxt    = i_redirect_target;
                        w_flush_nxt = 1'b1;
                    end
                    if (w_timeout) begin
                        w_state_nxt     = S_HALT;
                        w_fetch_req_nxt = 1'b0;
                        w_halted_nxt    = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (i_halt) begin
                    w_halt_pend_nxt = 1'b1;
                end
                if (i_redirect_valid || io_bus.instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    if (i_redirect_valid) begin
                        w_pc_nxt = i_redirect_target;
                    end
                    if (i_halt || r_halt_pend) begin
                        w_state_nxt  = S_HALT;
                        w_halted_nxt = 1'b1;
                    end else if (i_run) begin
                        w_state_nxt      = S_REQ;
                        w_fetch_req_nxt  = 1'b1;
                        w_fetch_addr_nxt = i_redirect_valid ? i_redirect_target : r_pc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_HALT: begin
                w_fetch_req_nxt   = 1'b0;
                w_instr_valid_nxt = 1'b0;
                w_halted_nxt      = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and internal flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_VECTOR;
            r_fetch_req   <= 1'b0;
            r_fetch_addr  <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_flush       <= 1'b0;
            r_halt_pend   <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_fetch_req   <= w_fetch_req_nxt;
            r_fetch_addr  <= w_fetch_addr_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_halted      <= w_halted_nxt;
            r_flush       <= w_flush_nxt;
            r_halt_pend   <= w_halt_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fetch watchdog
    // ------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_fetch_err;

    // The counter counts REQ cycles without ack. It is zero whenever a new
    // request starts: entry from IDLE/HOLD, or a re-issue after an ack.
    // An ack in the limit cycle wins, because the ack branch is taken first.
    assign w_timeout = (r_state == S_REQ) && !io_bus.fetch_ack &&
                       (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt    <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= w_timeout;
            if ((r_state == S_REQ) && !io_bus.fetch_ack && !w_timeout) begin
                r_to_cnt <= r_to_cnt + CW'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign o_fetch_err = r_fetch_err;
`else
    // No watchdog: REQ waits indefinitely. The parameter is still referenced,
    // so both builds expose the same parameter list.
    assign w_timeout   = 1'b0 & (TIMEOUT_CYCLES != 0);
    assign o_fetch_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign io_bus.fetch_req   = r_fetch_req;
    assign io_bus.fetch_addr  = r_fetch_addr;
    assign io_bus.instr       = r_instr;
    assign io_bus.instr_valid = r_instr_valid;
    assign o_halted           = r_halted;
    assign o_pc               = r_pc;
    assign o_state            = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Purpose : self-checking bench for pc_sequencer. A memory responder acks
//           requests after a programmable latency and returns
//           mem_word(addr) = addr + 0xA0. Expected fetch addresses and
//           delivered words are queued when each scenario is set up. They are
//           popped when the DUT acks a fetch or completes a decode transfer.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd3;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic             clk;
    logic             reset;
    logic             run;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             halt;
    logic             halted;
    logic [WIDTH-1:0] pc;
    logic             fetch_err;
    logic [1:0]       state;

    pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

    pc_sequencer #(
        .WIDTH          (WIDTH),
        .RESET_VECTOR   (32'h0),
        .PC_STEP        (32'h1),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .io_bus            (bus),
        .i_run             (run),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_halt            (halt),
        .o_halted          (halted),
        .o_pc              (pc),
        .o_fetch_err       (fetch_err),
        .o_state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state and checker
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_addr_q[$];

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mem_word(input logic [WIDTH-1:0] a);
        return a + 32'hA0;
    endfunction

    // ------------------------------------------------------------------
    // Memory responder: acts 2ns after each posedge
    // ------------------------------------------------------------------
    int mem_lat   = 2;
    bit mem_en    = 1'b1;
    bit stray_ack = 1'b0;
    int mem_cnt   = 0;

    always @(posedge clk) begin
        #2;
        if (reset) begin
            bus.fetch_ack = 1'b0;
            mem_cnt       = 0;
        end else if (stray_ack) begin
            bus.fetch_ack  = 1'b1;
            bus.fetch_data = 32'hDEAD_BEEF;
        end else if (bus.fetch_ack) begin
            bus.fetch_ack = 1'b0;
            mem_cnt       = 0;
        end else if (bus.fetch_req && mem_en) begin
            if (mem_cnt >= mem_lat) begin
                bus.fetch_ack  = 1'b1;
                bus.fetch_data = mem_word(bus.fetch_addr);
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples on negedge
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev_addr = '0;
    bit               prev_wait = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.instr_valid && bus.instr_ready && !redirect_valid) begin
                check_eq("instr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_eq("instr", bus.instr, exp_q.pop_front());
            end
            if (bus.fetch_req && bus.fetch_ack) begin
                check_eq("ack_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                if (exp_addr_q.size() > 0) check_eq("fetch_addr", bus.fetch_addr, exp_addr_q.pop_front());
            end
            if (bus.fetch_req && prev_wait) check_eq("addr_stable", bus.fetch_addr, prev_addr);
            prev_wait = bus.fetch_req && !bus.fetch_ack;
            prev_addr = bus.fetch_addr;
        end else begin
            prev_wait = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks: inputs change 1ns after posedge
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count acks; once the n-th ack is seen, drop run before the next edge.
    task automatic wait_for_acks(input int n, input int budget);
        int k = 0;
        for (int i = 0; i < budget && k < n; i++) begin
            @(negedge clk);
            if (bus.fetch_req && bus.fetch_ack) k++;
        end
        check_eq("ack_count", 32'(k), 32'(n));
        step();
        run = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() + exp_addr_q.size()) != 0; i++) begin
            @(negedge clk);
        end
        check_eq("drain", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    // which: 0 = fetch_req, 1 = instr_valid
    task automatic wait_high(input int which, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? bus.fetch_req : bus.instr_valid;
        end
        check_eq((which == 0) ? "wait_req" : "wait_valid", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        run = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt = 1'b0;
        bus.instr_ready = 1'b0; bus.fetch_ack = 1'b0; bus.fetch_data = '0;
        reset = 1'b1;
        repeat (3) step();

        // Reset values
        @(negedge clk);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_req", 32'(bus.fetch_req), 32'd0);
        check_eq("rst_addr", bus.fetch_addr, 32'h0);
        check_eq("rst_instr", bus.instr, 32'h0);
        check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_err", 32'(fetch_err), 32'd0);
        check_eq("rst_state", 32'(state), 32'(ST_IDLE));
        step();
        reset = 1'b0;

        // Sequential fetch: addresses 0,1,2 -> A0,A1,A2
        mem_lat = 2; bus.instr_ready = 1'b1;
        for (int a = 0; a < 3; a++) begin
            exp_addr_q.push_back(32'(a));
            exp_q.push_back(mem_word(32'(a)));
        end
        step(); run = 1'b1;
        wait_for_acks(3, 60);
        wait_drain(20);
        step(); @(negedge clk);
        check_eq("seq_pc", pc, 32'h3);
        check_eq("seq_req_idle", 32'(bus.fetch_req), 32'd0);
        check_eq("seq_state", 32'(state), 32'(ST_IDLE));

        // Decode stall in HOLD for 5 cycles
        bus.instr_ready = 1'b0;
        exp_addr_q.push_back(32'h3); exp_q.push_back(mem_word(32'h3));
        step(); run = 1'b1;
        wait_for_acks(1, 40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_instr", bus.instr, 32'hA3);
            check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
            check_eq("hold_no_req", 32'(bus.fetch_req), 32'd0);
            check_eq("hold_pc", pc, 32'h4);
        end
        step(); bus.instr_ready = 1'b1;
        wait_drain(10);

        // Redirect in IDLE to 5, then redirect to 0x40 while REQ waits on addr 5
        step(); redirect_valid = 1'b1; redirect_target = 32'h5;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("idle_redir_pc", pc, 32'h5);
        mem_lat = 4;
        exp_addr_q.push_back(32'h5); exp_addr_q.push_back(32'h40);
        exp_q.push_back(mem_word(32'h40));
        step(); run = 1'b1;
        wait_high(0, 10);
        step(); redirect_valid = 1'b1; redirect_target = 32'h40;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("req_redir_pc", pc, 32'h40);
        check_eq("req_addr_held", bus.fetch_addr, 32'h5);
        wait_for_acks(2, 60);
        wait_drain(20);
        check_eq("req_redir_pc_after", pc, 32'h41);

        // Redirect to 0x80 in HOLD with instr_ready high the same cycle
        bus.instr_ready = 1'b0; mem_lat = 1;
        exp_addr_q.push_back(32'h41); exp_addr_q.push_back(32'h80);
        exp_q.push_back(mem_word(32'h80));
        step(); run = 1'b1;
        wait_high(1, 20);
        step(); bus.instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("squash_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("squash_addr", bus.fetch_addr, 32'h80);
        check_eq("squash_req", 32'(bus.fetch_req), 32'd1);
        wait_for_acks(1, 40);
        wait_drain(20);
        check_eq("squash_pc", pc, 32'h81);

        // Halt pulse mid-REQ: word still delivered, then HALT until reset
        mem_lat = 3;
        exp_addr_q.push_back(32'h81); exp_q.push_back(mem_word(32'h81));
        step(); run = 1'b1;
        wait_high(0, 10);
        step(); halt = 1'b1;
        step(); halt = 1'b0;
        wait_drain(40);
        step(); redirect_valid = 1'b1; redirect_target = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("halt_halted", 32'(halted), 32'd1);
            check_eq("halt_no_req", 32'(bus.fetch_req), 32'd0);
            check_eq("halt_no_valid", 32'(bus.instr_valid), 32'd0);
        end
        check_eq("halt_pc_kept", pc, 32'h82);
        step(); redirect_valid = 1'b0; run = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_pc", pc, 32'h0);
        check_eq("async_rst_halted", 32'(halted), 32'd0);
        check_eq("async_rst_state", 32'(state), 32'(ST_IDLE));
        step(); reset = 1'b0;

        // Stray ack in IDLE, then PC wrap at 0xFFFFFFFF
        bus.instr_ready = 1'b1; mem_lat = 0;
        step(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step(); redirect_valid = 1'b0; stray_ack = 1'b1;
        step(); stray_ack = 1'b0;
        @(negedge clk);
        check_eq("stray_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("stray_state", 32'(state), 32'(ST_IDLE));
        check_eq("stray_pc", pc, 32'hFFFF_FFFF);
        exp_addr_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0000_009F);
        step(); run = 1'b1;
        wait_for_acks(1, 20);
        wait_drain(10);
        check_eq("wrap_pc", pc, 32'h0);

        // Halt in IDLE
        step(); halt = 1'b1;
        step(); halt = 1'b0;
        @(negedge clk);
        check_eq("idle_halt", 32'(halted), 32'd1);
        check_eq("idle_halt_state", 32'(state), 32'(ST_HALT));
        step(); reset = 1'b1;
        step(); reset = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: no ack for TIMEOUT cycles
        begin
            int  cycles = 0;
            bit  seen   = 1'b0;
            mem_en = 1'b0;
            step(); run = 1'b1;
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge clk);
                if (bus.fetch_req) cycles++;
                if (fetch_err) seen = 1'b1;
            end
            check_eq("to_err_seen", 32'(seen), 32'd1);
            check_eq("to_req_cycles", 32'(cycles), 32'(TIMEOUT));
            check_eq("to_halted", 32'(halted), 32'd1);
            @(negedge clk);
            check_eq("to_err_pulse", 32'(fetch_err), 32'd0);
            check_eq("to_req_dropped", 32'(bus.fetch_req), 32'd0);
            step(); run = 1'b0; mem_en = 1'b1;
        end
`endif

        check_eq("queues_empty", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences fetches for the processor core. It issues word-addressed fetch requests to instruction memory over a req/ack handshake and hands fetched words downstream over a valid/ready handshake. It also applies branch redirects and stops the core on halt. It replaces free-running PC increment with an explicit fetch FSM.

Parameters:
WIDTH, 32, PC and instruction width in bits
RESET_VECTOR, 0, PC value after reset
PC_STEP, 1, PC increment per accepted fetch (word addressing)
TIMEOUT_CYCLES, 16, fetch watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all state changes on posedge
reset  in  1  asynchronous, active-high
run  in  1  permits new fetches
fetch_req  out  1  fetch request to instruction memory
fetch_addr  out  WIDTH  fetch address; stable while fetch_req=1
fetch_ack  in  1  memory completes request; fetch_data is valid this cycle
fetch_data  in  WIDTH  fetched instruction word
instr  out  WIDTH  instruction to decode
instr_valid  out  1  instr is valid
instr_ready  in  1  decode accepts instr
redirect_valid  in  1  branch/jump taken
redirect_target  in  WIDTH  new PC
halt  in  1  stop request
halted  out  1  core halted
pc  out  WIDTH  current PC (address of next fetch)
fetch_err  out  1  watchdog pulse (optional feature only)

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values: pc=RESET_VECTOR, state=IDLE, fetch_req=0, fetch_addr=0, instr=0, instr_valid=0, halted=0, fetch_err=0, internal flush and halt_pend flags=0. Reset mid-transaction abandons the outstanding request with no completion.
- States: IDLE, REQ, HOLD, HALT. All outputs are registered.
- IDLE: if run=1, go to REQ with fetch_addr<=pc and fetch_req<=1 on the next edge. If run=0, stay in IDLE.
- REQ: fetch_req=1 and fetch_addr is held constant until fetch_ack. On ack with flush=0: instr<=fetch_data, instr_valid<=1, pc<=pc+PC_STEP, fetch_req<=0, go to HOLD. Request-to-instr_valid latency is 1 cycle after ack.
- HOLD: instr_valid stays 1 and instr is stable until instr_ready=1. On that handshake edge, instr_valid<=0 and the next state is chosen in this priority: halt or halt_pend goes to HALT; else run=1 goes to REQ (fetch_addr<=pc); else IDLE. There is a one-cycle gap between handshakes; no back-to-back fetch.
- Redirect has priority over increment. A redirect in HALT is ignored.
  - Redirect in IDLE: pc<=redirect_target.
  - Redirect in REQ on the same cycle as ack: discard data (instr_valid stays 0), pc<=target, fetch_addr<=target, stay in REQ.
  - Redirect in REQ without ack: pc<=target, flush<=1; the request continues unchanged. On the later ack: discard data, flush<=0, re-issue at fetch_addr<=pc.
  - Redirect in HOLD: squash, so instr_valid<=0 next edge even if instr_ready is high, and pc<=target. Then go to REQ if run=1, else IDLE.
- Halt:
  - In IDLE: go to HALT next edge.
  - In REQ: set halt_pend, finish the request, deliver the word (unless flushed), then take HALT from HOLD. A flushed request with halt_pend goes directly to HALT on ack.
  - HALT: halted=1, fetch_req=0, instr_valid=0. Only reset exits HALT.
- run deasserted in REQ does not cancel the outstanding request.
- Arithmetic: pc+PC_STEP wraps modulo 2^WIDTH (0xFFFFFFFF+1 → 0).
- fetch_ack outside REQ is ignored.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, the block drops fetch_req, pulses fetch_err for one cycle, and goes to HALT with halted=1. An ack on that same cycle takes precedence: the fetch completes normally and no error is raised.
- Not defined: REQ waits indefinitely and fetch_err is tied 0.

Test Plan:
- Reset then run=1, memory acks after 2 cycles with 0xA0, 0xA1, 0xA2, decode ready always → fetch_addr 0, 1, 2; instr sequence A0, A1, A2; pc=3.
- instr_ready held 0 for 5 cycles in HOLD → instr and instr_valid stable for 5 cycles, no new fetch_req, pc unchanged.
- Redirect to 0x40 during REQ before ack at addr 5 → fetch_addr stays 5 until ack, data discarded, next fetch_addr=0x40, no instr_valid for the addr-5 word.
- redirect_valid (target 0x80) in HOLD with instr_ready=1 same cycle → instr_valid drops, next fetch_addr=0x80.
- halt asserted mid-REQ → the word is still delivered, then halted=1 and fetch_req stays 0 until reset; asynchronous reset mid-HALT restores pc=RESET_VECTOR.
- pc=0xFFFFFFFF, fetch acked → pc=0. With FETCH_TIMEOUT_EN and no ack for 16 cycles → fetch_err one-cycle pulse, halted=1.
